shiftleft_seq: RTL and testbench
================================

Name: shiftleft_seq

Overview:
Multi-cycle logical left shifter, the counterpart of the combinational shiftright unit in the URCPU datapath.
- Accepts an operand and shift amount over a valid/ready handshake.
- Shifts one bit per clock.
- Returns the result plus the last bit shifted out over a second valid/ready handshake.
- Used by the ALU shift path where area matters more than latency.

Parameters:
DATA_WIDTH, 20, operand, result and shift_amount width
CNT_WIDTH, 5, shift counter width; must hold DATA_WIDTH (ceil log2(DATA_WIDTH+1))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand/amount presented
start_ready  output  1  block can accept an operation
data_in  input  DATA_WIDTH  operand
shift_amount  input  DATA_WIDTH  unsigned shift count (full width, as on shiftright)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
data_out  output  DATA_WIDTH  shifted result
carry_out  output  1  last bit shifted out of MSB; 0 if amount is 0
busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (on rst_n low, immediately):
  - state=IDLE, data_out=0, carry_out=0, out_valid=0, busy=0, start_ready=1.
  - Internal count=0.
- States: IDLE, SHIFT, DONE. Registered state, encoding from the package.
- IDLE:
  - start_ready=1.
  - On start_valid (cycle T): load shreg<=data_in and carry<=0.
  - Load count<=min(shift_amount, DATA_WIDTH). Any amount >= DATA_WIDTH, including upper bits set, clamps to DATA_WIDTH.
  - If the clamped count is 0, go to DONE; else go to SHIFT.
- SHIFT:
  - Each cycle: carry<=shreg[DATA_WIDTH-1], shreg<=shreg<<1 (zero-fill LSB), count<=count-1.
  - When count==1 this cycle, go to DONE.
- DONE:
  - out_valid=1; data_out and carry_out are stable from registers.
  - Hold until out_ready is high, then go to IDLE (out_valid drops the next cycle).
- Latency: out_valid first high at cycle T+1+n, where n is the clamped count.
  - Amount 0 gives T+1; amount >= DATA_WIDTH gives T+1+DATA_WIDTH.
- Handshake rules:
  - start_ready is low in SHIFT and DONE; start_valid is ignored there.
  - No overlap: a new start is accepted at the earliest one cycle after the DONE handshake.
  - start_ready is a function of state only, with no combinational path from out_ready.
  - data_in and shift_amount are sampled only at acceptance; later changes have no effect.
- Output stability: data_out and carry_out update only while the block is internally shifting; they are never exposed as valid until DONE.
  - In IDLE they hold the last result.
- Backpressure: in DONE with out_ready low indefinitely, all outputs hold.
- Reset mid-operation: an asynchronous rst_n assertion in any state returns the block to reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- Width rule: the comparison against DATA_WIDTH uses the full shift_amount width, so no truncation aliasing is allowed (e.g. 2^CNT_WIDTH+3 must clamp, not shift by 3).

Decomposition:
- Shared package (urcpu_pkg):
  - DATA_WIDTH default.
  - CNT_WIDTH derivation.
  - Shift-unit state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- No sub-module; a single module. The shared package lets shiftright and shiftleft_seq agree on widths.

Test Plan:
- data_in=20'b10101010101010101010, amount=3 -> data_out=20'h55550, carry_out=1, out_valid at T+4.
- data_in=20'b10001010100010101010, amount=7 -> data_out=20'h45500, carry_out=1, out_valid at T+8.
- data_in=20'hABCDE, amount=0 -> data_out=20'hABCDE, carry_out=0, out_valid at T+1.
- data_in=20'h00001, amount=25 (and again with amount=20'h80003) -> data_out=0, carry_out=1, out_valid at T+21. Confirms clamping with no aliasing.
- Backpressure: amount=2, out_ready held low 10 cycles -> out_valid, data_out and carry_out stable, start_ready=0. A second start_valid pulse during the hold is ignored. out_ready=1 -> start_ready returns the cycle after.
- Reset mid-shift: amount=15, rst_n low at T+5 -> all outputs at reset values immediately, no out_valid. After release, amount=1 on data_in=20'h80001 -> data_out=20'h00002, carry_out=1.

Source files
------------

// File: rtl/urcpu_pkg.sv
// Shared URCPU datapath constants: operand width, shift counter width and the
// state encoding used by the sequential shift units.
package urcpu_pkg;

  localparam int URCPU_DATA_WIDTH = 20;
  // Counter must be able to hold the value DATA_WIDTH itself, not just DATA_WIDTH-1.
  localparam int URCPU_CNT_WIDTH  = $clog2(URCPU_DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shiftleft_seq.sv
// Multi-cycle logical left shifter: one bit per clock, result and last bit
// shifted out returned over a valid/ready handshake.
module shiftleft_seq
  import urcpu_pkg::*;
#(
  parameter int DATA_WIDTH = URCPU_DATA_WIDTH,
  parameter int CNT_WIDTH  = URCPU_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] shift_amount,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  carry_out,
  output logic                  busy
);

  shift_state_e          r_state;
  shift_state_e          w_nextState;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_carry;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_clampCnt;
  logic                  w_accept;

  // Compare on the full operand width so large amounts never alias to small ones.
  always_comb begin
    w_clampCnt = shift_amount[CNT_WIDTH-1:0];
    if (shift_amount >= DATA_WIDTH'(DATA_WIDTH)) begin
      w_clampCnt = CNT_WIDTH'(DATA_WIDTH);
    end
  end

  assign w_accept = (r_state == IDLE) && start_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_nextState = (w_clampCnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == CNT_WIDTH'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == IDLE);
    out_valid   = (r_state == DONE);
    busy        = (r_state == SHIFT) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_shreg <= data_in;
      r_carry <= 1'b0;
      r_count <= w_clampCnt;
    end else if (r_state == SHIFT) begin
      r_carry <= r_shreg[DATA_WIDTH-1];
      r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
      r_count <= r_count - CNT_WIDTH'(1);
    end
  end

  assign data_out  = r_shreg;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_shiftleft_seq.sv
// Directed self-checking bench for shiftleft_seq: latency, results, clamping,
// backpressure and asynchronous reset during a shift.
module tb_shiftleft_seq;

  localparam int DW = 20;

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [DW-1:0] data_in;
  logic [DW-1:0] shift_amount;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic          carry_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  shiftleft_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .carry_out    (carry_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one operation at a negedge; it is accepted on the following posedge.
  // Inputs are scrambled afterwards to show they are sampled only at acceptance.
  task automatic applyStimulus(input logic [DW-1:0] d, input logic [DW-1:0] a);
    @(negedge clk);
    start_valid  = 1'b1;
    data_in      = d;
    shift_amount = a;
    @(posedge clk);
    #1;
    start_valid  = 1'b0;
    data_in      = DW'($urandom);
    shift_amount = DW'($urandom);
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic runOp(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] a,
                       input int expLat, input logic [DW-1:0] expData, input logic expCarry);
    int lat;
    applyStimulus(d, a);
    waitValid(lat);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_data"}, data_out, expData);
    checkOutput({tag, "_carry"}, carry_out, expCarry);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    checkOutput({tag, "_start_ready"}, start_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, out_valid, 1'b0);
    checkOutput({tag, "_ready_back"}, start_ready, 1'b1);
    checkOutput({tag, "_idle_hold"}, data_out, expData);
  endtask

  initial begin
    int lat;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    out_ready    = 1'b0;
    data_in      = '0;
    shift_amount = '0;
    #1;
    checkOutput("rst_start_ready", start_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data", data_out, 20'h00000);
    checkOutput("rst_carry", carry_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("alt3", 20'b10101010101010101010, 20'd3, 4, 20'h55550, 1'b1);
    runOp("mix7", 20'b10001010100010101010, 20'd7, 8, 20'h45500, 1'b1);
    runOp("zero", 20'hABCDE, 20'd0, 1, 20'hABCDE, 1'b0);
    runOp("clamp25", 20'h00001, 20'd25, 21, 20'h00000, 1'b1);
    runOp("clampAlias", 20'h00001, 20'h80003, 21, 20'h00000, 1'b1);
    runOp("exact20", 20'hFFFFF, 20'd20, 21, 20'h00000, 1'b1);

    // Backpressure: result must hold while out_ready stays low.
    applyStimulus(20'h60001, 20'd2);
    waitValid(lat);
    checkOutput("bp_latency", lat, 3);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start_valid = 1'b1;
      if (i == 5) data_in = 20'h12345;
      if (i == 5) shift_amount = 20'd1;
      @(negedge clk);
      start_valid = 1'b0;
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_data", data_out, 20'h80004);
      checkOutput("bp_carry", carry_out, 1'b1);
      checkOutput("bp_start_ready", start_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_ready_back", start_ready, 1'b1);
    checkOutput("bp_valid_drop", out_valid, 1'b0);
    checkOutput("bp_data_after", data_out, 20'h80004);
    @(negedge clk);
    checkOutput("bp_no_restart", busy, 1'b0);

    // Asynchronous reset mid-shift discards the operation.
    applyStimulus(20'hFFFFF, 20'd15);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_start_ready", start_ready, 1'b1);
    checkOutput("mrst_out_valid", out_valid, 1'b0);
    checkOutput("mrst_busy", busy, 1'b0);
    checkOutput("mrst_data", data_out, 20'h00000);
    checkOutput("mrst_carry", carry_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("mrst_no_valid", out_valid, 1'b0);
    end
    runOp("post1", 20'h80001, 20'd1, 2, 20'h00002, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
